// File: rtl/pcl_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pcl_unit_if: command, data and PCH-handshake bundle for pcl_unit |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface pcl_unit_if;
  logic       pc_inc;
  logic       load_db;
  logic       push_vector;
  logic [1:0] vector_sel;
  logic       branch_take;
  logic [7:0] db_in;
  logic       carry_done;
  logic [7:0] address_low_out;
  logic [7:0] db_out;
  logic       carry_to_pch;
  logic       borrow_to_pch;
  logic       page_cross;
  logic       busy;

  modport master (
    output pc_inc, load_db, push_vector, vector_sel, branch_take, db_in, carry_done,
    input  address_low_out, db_out, carry_to_pch, borrow_to_pch, page_cross, busy
  );

  modport slave (
    input  pc_inc, load_db, push_vector, vector_sel, branch_take, db_in, carry_done,
    output address_low_out, db_out, carry_to_pch, borrow_to_pch, page_cross, busy
  );
endinterface
`default_nettype wire

// File: rtl/pcl_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pcl_unit: 65C02 PC low byte with increment/load/vector/branch    |
// | and a PCH carry/borrow request handshake. Revision: 1.0          |
// +------------------------------------------------------------------+
module pcl_unit (
  input  wire logic   fclk,
  input  wire logic   reset,
  pcl_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WAIT_CLR = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pcl_q, pcl_d;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;
  logic       page_cross_q, page_cross_d;
  logic [8:0] inc_sum;
  logic [8:0] br_sum;
  logic [7:0] vector_lo;

  always_comb begin
    inc_sum = {1'b0, pcl_q} + 9'd1;
    br_sum  = {1'b0, pcl_q} + {1'b0, bus.db_in};
    case (bus.vector_sel)
      2'b00:   vector_lo = 8'hFA;
      2'b01:   vector_lo = 8'hFC;
      default: vector_lo = 8'hFE;
    endcase

    state_d      = state_q;
    pcl_d        = pcl_q;
    carry_d      = carry_q;
    borrow_d     = borrow_q;
    page_cross_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.load_db) begin
          pcl_d = bus.db_in;
        end else if (bus.push_vector) begin
          pcl_d = vector_lo;
        end else if (bus.branch_take) begin
          pcl_d = br_sum[7:0];
          // Offset sign decides which carry-out value means a page was left.
          if (!bus.db_in[7] && br_sum[8]) begin
            carry_d      = 1'b1;
            page_cross_d = 1'b1;
            state_d      = ST_WAIT_ACK;
          end else if (bus.db_in[7] && !br_sum[8]) begin
            borrow_d     = 1'b1;
            page_cross_d = 1'b1;
            state_d      = ST_WAIT_ACK;
          end
        end else if (bus.pc_inc) begin
          pcl_d = inc_sum[7:0];
          if (inc_sum[8]) begin
            carry_d      = 1'b1;
            page_cross_d = 1'b1;
            state_d      = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (bus.carry_done) begin
          carry_d  = 1'b0;
          borrow_d = 1'b0;
          state_d  = ST_WAIT_CLR;
        end
      end
      ST_WAIT_CLR: begin
        // Wait for the ack to fall so it cannot complete the next request.
        if (!bus.carry_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pcl_q        <= 8'h00;
      carry_q      <= 1'b0;
      borrow_q     <= 1'b0;
      page_cross_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcl_q        <= pcl_d;
      carry_q      <= carry_d;
      borrow_q     <= borrow_d;
      page_cross_q <= page_cross_d;
    end
  end

  assign bus.address_low_out = pcl_q;
  assign bus.db_out          = pcl_q;
  assign bus.carry_to_pch    = carry_q;
  assign bus.borrow_to_pch   = borrow_q;
  assign bus.page_cross      = page_cross_q;
  assign bus.busy            = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pcl_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pcl_unit: directed self-checking bench for pcl_unit           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_pcl_unit;

  logic fclk  = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  pcl_unit_if bus ();

  pcl_unit dut (
    .fclk  (fclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 fclk = ~fclk;

  task automatic tick;
    @(posedge fclk);
    #1;
  endtask

  task automatic clear_cmds;
    bus.pc_inc      = 1'b0;
    bus.load_db     = 1'b0;
    bus.push_vector = 1'b0;
    bus.branch_take = 1'b0;
    bus.vector_sel  = 2'b00;
    bus.db_in       = 8'h00;
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load_db = 1'b1;
    bus.db_in   = v;
    tick();
    clear_cmds();
  endtask

  task automatic do_branch(input logic [7:0] off);
    bus.branch_take = 1'b1;
    bus.db_in       = off;
    tick();
    clear_cmds();
  endtask

  // Acknowledge one cycle, drop ack, one more cycle back to IDLE.
  task automatic do_ack;
    bus.carry_done = 1'b1;
    tick();
    bus.carry_done = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({bus.address_low_out, bus.db_out, bus.carry_to_pch, bus.borrow_to_pch,
         bus.page_cross, bus.busy} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got addr=%h db=%h c=%b b=%b pc=%b busy=%b required all 0",
               bus.address_low_out, bus.db_out, bus.carry_to_pch, bus.borrow_to_pch,
               bus.page_cross, bus.busy);
    end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_vector;
    logic [7:0] exp_v [4];
    exp_v[0] = 8'hFA; exp_v[1] = 8'hFC; exp_v[2] = 8'hFE; exp_v[3] = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      bus.push_vector = 1'b1;
      bus.vector_sel  = 2'(i);
      tick();
      clear_cmds();
      vectors++;
      if (bus.address_low_out !== exp_v[i] || bus.db_out !== exp_v[i]) begin
        miscompares++;
        $display("FAIL vector_sel%0d: got addr=%h db=%h required %h",
                 i, bus.address_low_out, bus.db_out, exp_v[i]);
      end
      vectors++;
      if ({bus.carry_to_pch, bus.borrow_to_pch, bus.page_cross, bus.busy} !== 4'b0000) begin
        miscompares++;
        $display("FAIL vector_noreq%0d: got c/b/pc/busy=%b required 0000", i,
                 {bus.carry_to_pch, bus.borrow_to_pch, bus.page_cross, bus.busy});
      end
    end
  endtask

  task automatic test_inc_carry;
    do_load(8'hFE);
    bus.pc_inc = 1'b1;
    tick();
    vectors++;
    if (bus.address_low_out !== 8'hFF || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL inc_to_ff: got %h busy=%b required ff busy=0", bus.address_low_out, bus.busy);
    end
    tick();
    clear_cmds();
    vectors++;
    if ({bus.address_low_out, bus.carry_to_pch, bus.borrow_to_pch, bus.page_cross, bus.busy}
        !== {8'h00, 4'b1011}) begin
      miscompares++;
      $display("FAIL inc_wrap: got addr=%h c/b/pc/busy=%b required 00 1011", bus.address_low_out,
               {bus.carry_to_pch, bus.borrow_to_pch, bus.page_cross, bus.busy});
    end
    tick();
    tick();
    vectors++;
    if ({bus.carry_to_pch, bus.page_cross, bus.busy} !== 3'b101) begin
      miscompares++;
      $display("FAIL inc_hold: got c/pc/busy=%b required 101",
               {bus.carry_to_pch, bus.page_cross, bus.busy});
    end
    bus.carry_done = 1'b1;
    tick();
    vectors++;
    if ({bus.carry_to_pch, bus.busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL inc_ack_edge: got c/busy=%b required 01", {bus.carry_to_pch, bus.busy});
    end
    tick();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL inc_ack_held: got busy=%b required 1", bus.busy);
    end
    bus.carry_done = 1'b0;
    tick();
    vectors++;
    if (bus.busy !== 1'b0 || bus.carry_to_pch !== 1'b0) begin
      miscompares++;
      $display("FAIL inc_idle: got busy=%b c=%b required 0 0", bus.busy, bus.carry_to_pch);
    end
  endtask

  task automatic test_branch;
    do_load(8'hF0);
    do_branch(8'h20);
    vectors++;
    if ({bus.address_low_out, bus.carry_to_pch, bus.borrow_to_pch, bus.page_cross}
        !== {8'h10, 3'b101}) begin
      miscompares++;
      $display("FAIL br_fwd: got addr=%h c/b/pc=%b required 10 101", bus.address_low_out,
               {bus.carry_to_pch, bus.borrow_to_pch, bus.page_cross});
    end
    do_ack();
    do_branch(8'hE0);
    vectors++;
    if ({bus.address_low_out, bus.carry_to_pch, bus.borrow_to_pch, bus.page_cross}
        !== {8'hF0, 3'b011}) begin
      miscompares++;
      $display("FAIL br_back: got addr=%h c/b/pc=%b required f0 011", bus.address_low_out,
               {bus.carry_to_pch, bus.borrow_to_pch, bus.page_cross});
    end
    do_ack();
    do_load(8'h40);
    do_branch(8'hF0);
    vectors++;
    if ({bus.address_low_out, bus.carry_to_pch, bus.borrow_to_pch, bus.busy}
        !== {8'h30, 3'b000}) begin
      miscompares++;
      $display("FAIL br_back_same: got addr=%h c/b/busy=%b required 30 000", bus.address_low_out,
               {bus.carry_to_pch, bus.borrow_to_pch, bus.busy});
    end
    do_load(8'h80);
    do_branch(8'h80);
    vectors++;
    if ({bus.address_low_out, bus.carry_to_pch, bus.borrow_to_pch, bus.busy}
        !== {8'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL br_80_80: got addr=%h c/b/busy=%b required 00 000", bus.address_low_out,
               {bus.carry_to_pch, bus.borrow_to_pch, bus.busy});
    end
    // Ack already high when the request rises: accepted on the first WAIT_ACK edge.
    bus.carry_done = 1'b1;
    do_branch(8'hFF);
    vectors++;
    if ({bus.address_low_out, bus.carry_to_pch, bus.borrow_to_pch, bus.busy}
        !== {8'hFF, 3'b011}) begin
      miscompares++;
      $display("FAIL br_00_ff: got addr=%h c/b/busy=%b required ff 011", bus.address_low_out,
               {bus.carry_to_pch, bus.borrow_to_pch, bus.busy});
    end
    tick();
    vectors++;
    if ({bus.borrow_to_pch, bus.busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL br_early_ack: got b/busy=%b required 01", {bus.borrow_to_pch, bus.busy});
    end
    bus.carry_done = 1'b0;
    tick();
  endtask

  task automatic test_busy_ignore;
    do_load(8'hFF);
    bus.pc_inc = 1'b1;
    tick();
    clear_cmds();
    bus.load_db = 1'b1;
    bus.pc_inc  = 1'b1;
    bus.db_in   = 8'h55;
    tick();
    clear_cmds();
    vectors++;
    if (bus.address_low_out !== 8'h00 || bus.carry_to_pch !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_ack_hold: got addr=%h c=%b required 00 1", bus.address_low_out,
               bus.carry_to_pch);
    end
    bus.carry_done = 1'b1;
    tick();
    bus.load_db = 1'b1;
    bus.db_in   = 8'h55;
    tick();
    clear_cmds();
    vectors++;
    if (bus.address_low_out !== 8'h00 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_clr_hold: got addr=%h busy=%b required 00 1", bus.address_low_out,
               bus.busy);
    end
    bus.carry_done = 1'b0;
    tick();
    do_load(8'h55);
    vectors++;
    if (bus.address_low_out !== 8'h55) begin
      miscompares++;
      $display("FAIL busy_after: got %h required 55", bus.address_low_out);
    end
  endtask

  task automatic test_priority;
    bus.load_db = 1'b1; bus.push_vector = 1'b1; bus.pc_inc = 1'b1; bus.branch_take = 1'b1;
    bus.db_in = 8'h12;
    tick();
    clear_cmds();
    vectors++;
    if (bus.address_low_out !== 8'h12) begin
      miscompares++;
      $display("FAIL prio_load: got %h required 12", bus.address_low_out);
    end
    bus.push_vector = 1'b1; bus.branch_take = 1'b1; bus.pc_inc = 1'b1;
    bus.vector_sel = 2'b00; bus.db_in = 8'h03;
    tick();
    clear_cmds();
    vectors++;
    if (bus.address_low_out !== 8'hFA) begin
      miscompares++;
      $display("FAIL prio_vector: got %h required fa", bus.address_low_out);
    end
    bus.branch_take = 1'b1; bus.pc_inc = 1'b1; bus.db_in = 8'h03;
    tick();
    clear_cmds();
    vectors++;
    if (bus.address_low_out !== 8'hFD) begin
      miscompares++;
      $display("FAIL prio_branch: got %h required fd", bus.address_low_out);
    end
  endtask

  task automatic test_reset_mid;
    do_load(8'hF0);
    do_branch(8'h20);
    vectors++;
    if (bus.carry_to_pch !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_setup: got c=%b required 1", bus.carry_to_pch);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({bus.address_low_out, bus.db_out, bus.carry_to_pch, bus.borrow_to_pch,
         bus.page_cross, bus.busy} !== 20'h0) begin
      miscompares++;
      $display("FAIL rst_mid_async: got addr=%h db=%h c=%b b=%b pc=%b busy=%b required all 0",
               bus.address_low_out, bus.db_out, bus.carry_to_pch, bus.borrow_to_pch,
               bus.page_cross, bus.busy);
    end
    tick();
    #2 reset = 1'b0;
    bus.pc_inc = 1'b1;
    tick();
    clear_cmds();
    vectors++;
    if (bus.address_low_out !== 8'h01 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_inc: got %h busy=%b required 01 0", bus.address_low_out, bus.busy);
    end
  endtask

  initial begin
    clear_cmds();
    bus.carry_done = 1'b0;
    test_reset();
    test_vector();
    test_inc_carry();
    test_branch();
    test_busy_ignore();
    test_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcl_unit.md
# pcl_unit

Program-counter low-byte stage of the 65C02 core, directly upstream of the PC high-byte register. It holds PCL and drives it onto the low address bus and data bus. It performs increment, data-bus load, vector load and signed relative-branch add. Page crossings are forwarded to the high-byte stage through a `carry_to_pch`/`carry_done` handshake, with a `busy` stall to the sequencer while the handshake is open.

## Interface
- No parameters.
- `fclk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `pc_inc` in 1: increment PCL.
- `load_db` in 1: load PCL from `db_in` (JMP/RTS/RTI low byte).
- `push_vector` in 1: load vector low byte selected by `vector_sel`.
- `vector_sel` in 2: 00 = FA (NMI), 01 = FC (RESET), 10/11 = FE (IRQ/BRK).
- `branch_take` in 1: add signed offset on `db_in` to PCL.
- `db_in` in 8: data bus input (load value or branch offset).
- `carry_done` in 1: high-byte stage acknowledge.
- `address_low_out` out 8: PCL to address bus.
- `db_out` out 8: PCL to data bus (push of PCL).
- `carry_to_pch` out 1: request PCH +1.
- `borrow_to_pch` out 1: request PCH −1 (backward branch crossing).
- `page_cross` out 1: one-cycle pulse when a crossing request is issued.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Register `pcl[7:0]`; `address_low_out = db_out = pcl`.
- States: IDLE, WAIT_ACK, WAIT_CLR.
- Commands are sampled only in IDLE; in WAIT_ACK/WAIT_CLR all commands are ignored and `pcl` holds.
- Command priority in IDLE: `load_db` > `push_vector` > `branch_take` > `pc_inc`.
- `load_db`: pcl ← db_in; no request.
- `push_vector`: pcl ← FA/FC/FE per `vector_sel`; no request.
- `pc_inc`: 9-bit sum = pcl + 1; pcl ← sum[7:0]. If pcl was FF: pcl ← 00, `carry_to_pch` ← 1, → WAIT_ACK.
- `branch_take`: sum = {0,pcl} + {0,db_in} as 9-bit; pcl ← sum[7:0].
  - Forward crossing when db_in[7]=0 and sum[8]=1: `carry_to_pch` ← 1.
  - Backward crossing when db_in[7]=1 and sum[8]=0: `borrow_to_pch` ← 1.
  - Either crossing → WAIT_ACK; otherwise stay IDLE.
- WAIT_ACK: request held high until `carry_done` is sampled 1. On that edge the request drops to 0 → WAIT_CLR.
- WAIT_CLR: stays until `carry_done` is sampled 0 → IDLE. This prevents a stale ack from completing the next request.
- `carry_to_pch` and `borrow_to_pch` are never high together.
- `page_cross` is registered, high for exactly the cycle after the edge that sets a request.

## Timing
- Reset (async, immediate): pcl = 00, state IDLE; all outputs 0 (`address_low_out`, `db_out`, `carry_to_pch`, `borrow_to_pch`, `page_cross`, `busy`).
- Reset asserted mid-handshake aborts it: request drops immediately, state IDLE.
- Command latency: 1 clock; new `pcl` is visible after the sampling edge.
- Crossing request rises on the same edge that updates `pcl`.
- Minimum busy window with ack in the next cycle and ack cleared one cycle later: 2 cycles (WAIT_ACK 1, WAIT_CLR 1).
- `carry_done` already high on entry to WAIT_ACK is accepted on the first WAIT_ACK edge.
- `busy` is combinational from state. The sequencer must stall while it is high.
- Wrap-around:
  - FF + 1 = 00 with carry.
  - Branch 80 + 80 → 00 with no request (backward, no borrow across, sum[8]=1 and db_in[7]=1).
  - 00 + FF → FF with borrow.

## Test plan
- Reset then `push_vector` with `vector_sel`=01 → `address_low_out`=FC next cycle; no request; busy 0.
- `load_db` with db_in=FE, then `pc_inc` ×2 → FF then 00.
  - On the 00 edge: `carry_to_pch`=1, `page_cross` pulse, busy=1.
  - Ack after 3 cycles → request low on ack edge; IDLE one cycle after ack falls.
- pcl=F0, `branch_take` db_in=20 → pcl=10, `carry_to_pch`=1. pcl=10, db_in=E0 (−32) → F0, `borrow_to_pch`=1. pcl=40, db_in=F0 → 30, no request.
- While busy, pulse `load_db` (db_in=55) and `pc_inc` → pcl unchanged; after handshake completes, `load_db` with 55 → 55.
- Simultaneous `load_db`=1, `push_vector`=1, `pc_inc`=1 in IDLE with db_in=12 → pcl=12.
- Assert `reset` while WAIT_ACK with `carry_to_pch` high → outputs 0 immediately without a clock edge; after release, `pc_inc` from 00 → 01.
